// File: rtl/div_iter.sv
// rtl/div_iter.sv - multi-cycle radix-2 restoring divider for DIV/DIVU in EX
// Result is {remainder, quotient}. The pipeline is held via div_stall while a divide is in flight.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               flush,
  input  logic               stall_ex,
  output logic               div_stall,
  output logic               result_valid,
  output logic [2*WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  // Before the final step the partial remainder never reaches 2^(WIDTH-1), so its MSB is not stored.
  logic [WIDTH-2:0]   rem_q, rem_d;
  logic               sign_q_q, sign_q_d;
  logic               sign_r_q, sign_r_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH-1:0]   trial, trial_sub, rem_next, quot_next;
  logic [WIDTH-1:0]   quot_fin, rem_fin;
  logic               qbit;

  always_comb begin
    a_abs     = (signed_div && a[WIDTH-1]) ? (~a + ONE) : a;
    b_abs     = (signed_div && b[WIDTH-1]) ? (~b + ONE) : b;
    trial     = {rem_q, dvd_q[WIDTH-1]};
    qbit      = (trial >= dvs_q);
    trial_sub = trial - dvs_q;
    rem_next  = qbit ? trial_sub : trial;
    // The quotient bits are shifted into the vacated low end of the dividend register.
    quot_next = {dvd_q[WIDTH-2:0], qbit};
    quot_fin  = sign_q_q ? (~quot_next + ONE) : quot_next;
    rem_fin   = sign_r_q ? (~rem_next + ONE) : rem_next;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    sign_q_d = sign_q_q;
    sign_r_d = sign_r_q;
    result_d = result_q;

    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (b == '0) begin
              result_d = {a, {WIDTH{1'b1}}};
              state_d  = DONE;
            end else begin
              dvd_d    = a_abs;
              dvs_d    = b_abs;
              rem_d    = '0;
              cnt_d    = '0;
              sign_q_d = signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
              sign_r_d = signed_div & a[WIDTH-1];
              state_d  = BUSY;
            end
          end
        end
        BUSY: begin
          rem_d = rem_next[WIDTH-2:0];
          dvd_d = quot_next;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            result_d = {rem_fin, quot_fin};
            state_d  = DONE;
          end
        end
        DONE: begin
          if (!stall_ex) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      sign_q_q <= sign_q_d;
      sign_r_q <= sign_r_d;
      result_q <= result_d;
    end
  end

  assign div_stall    = ((state_q == IDLE) && start && !flush) || (state_q == BUSY);
  assign result_valid = (state_q == DONE);
  assign result       = result_q;

endmodule

// File: tb/tb_div_iter.sv
// tb/tb_div_iter.sv - self-checking bench for div_iter
// Directed and random divides are checked against a 64-bit arithmetic reference.
module tb_div_iter;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic           start = 1'b0;
  logic           signed_div = 1'b0;
  logic           flush = 1'b0;
  logic           stall_ex = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           div_stall;
  logic           result_valid;
  logic [2*W-1:0] result;

  int n_cmp = 0;
  int n_err = 0;

  div_iter #(.WIDTH(W)) dut (
    .clk(clk), .resetn(resetn), .start(start), .signed_div(signed_div),
    .a(a), .b(b), .flush(flush), .stall_ex(stall_ex),
    .div_stall(div_stall), .result_valid(result_valid), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_div(input logic sd, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    if (y == 32'd0) return {x, 32'hFFFF_FFFF};
    if (sd) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
    end else begin
      sx = longint'({32'd0, x});
      sy = longint'({32'd0, y});
    end
    q = sx / sy;
    r = sx % sy;
    return {r[31:0], q[31:0]};
  endfunction

  // Holds start until result_valid; lat counts edges from the start cycle to DONE.
  task automatic run_op(input logic sd, input logic [31:0] x, input logic [31:0] y,
                        output logic [63:0] res, output int lat, output int stalls);
    @(negedge clk);
    signed_div = sd; a = x; b = y; start = 1'b1;
    lat = 0; stalls = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (div_stall) stalls++;
      if (result_valid) break;
      @(negedge clk);
      lat++;
    end
    check("done_reached", {63'd0, result_valid}, 64'd1);
    res = result;
    start = 1'b0;
  endtask

  task automatic after_op(input string tag, input logic [63:0] held);
    @(negedge clk);
    #1;
    check({tag, "_idle_valid"}, {63'd0, result_valid}, 64'd0);
    check({tag, "_idle_stall"}, {63'd0, div_stall}, 64'd0);
    check({tag, "_held"}, result, held);
  endtask

  task automatic directed(input string tag, input logic sd, input logic [31:0] x,
                          input logic [31:0] y, input logic [63:0] exp);
    logic [63:0] res;
    int lat, stalls;
    int exp_lat;
    exp_lat = (y == 32'd0) ? 1 : 33;
    run_op(sd, x, y, res, lat, stalls);
    check({tag, "_result"}, res, exp);
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_stall_cycles"}, 64'(stalls), 64'(exp_lat));
    after_op(tag, exp);
  endtask

  initial begin
    logic [63:0] res, prev, exp;
    int lat, stalls, vcnt;
    logic sd;
    logic [31:0] x, y;

    repeat (2) @(negedge clk);
    #1;
    check("reset_result", result, 64'd0);
    check("reset_valid", {63'd0, result_valid}, 64'd0);
    check("reset_stall", {63'd0, div_stall}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    directed("divu_7_2", 1'b0, 32'd7, 32'd2, 64'h00000001_00000003);
    directed("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
    directed("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 64'h00000001_FFFFFFFD);
    directed("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000);
    directed("divu_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 64'h80000000_00000000);
    directed("divu_big", 1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 64'h7FFFFFFE_00000001);
    directed("divu_zero", 1'b0, 32'h1234_5678, 32'd0, 64'h12345678_FFFFFFFF);
    directed("div_zero", 1'b1, 32'h8765_4321, 32'd0, 64'h87654321_FFFFFFFF);

    for (int i = 0; i < 20; i++) begin
      sd = 1'($urandom_range(0, 1));
      x = $urandom;
      case ($urandom_range(0, 7))
        0:       y = 32'd0;
        1:       y = 32'($urandom_range(1, 15));
        2:       y = 32'd0 - 32'($urandom_range(1, 15));
        default: y = $urandom;
      endcase
      exp = ref_div(sd, x, y);
      run_op(sd, x, y, res, lat, stalls);
      check($sformatf("rand%0d_result", i), res, exp);
      check($sformatf("rand%0d_latency", i), 64'(lat), (y == 32'd0) ? 64'd1 : 64'd33);
      after_op($sformatf("rand%0d", i), exp);
    end

    // Flush while start is presented in IDLE: no stall, no operation.
    prev = result;
    @(negedge clk);
    a = 32'd50; b = 32'd3; signed_div = 1'b0; start = 1'b1; flush = 1'b1;
    #1;
    check("flush_idle_stall", {63'd0, div_stall}, 64'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    check("flush_idle_state", {62'd0, div_stall, result_valid}, 64'd0);
    check("flush_idle_held", result, prev);

    // Flush at BUSY cycle 10.
    @(negedge clk);
    a = 32'h1234; b = 32'd3; signed_div = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush_busy_stall", {63'd0, div_stall}, 64'd1);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_after_valid", {63'd0, result_valid}, 64'd0);
    check("flush_after_stall", {63'd0, div_stall}, 64'd0);
    check("flush_after_held", result, prev);
    directed("post_flush", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);

    // stall_ex holds DONE; start is ignored there.
    exp = ref_div(1'b1, 32'hFFFF_FF9C, 32'd9);
    run_op(1'b1, 32'hFFFF_FF9C, 32'd9, res, lat, stalls);
    check("stallex_result", res, exp);
    start = 1'b1; stall_ex = 1'b1;
    vcnt = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      if (!result_valid) break;
      vcnt++;
      check("stallex_stable", result, exp);
      check("stallex_no_stall", {63'd0, div_stall}, 64'd0);
      if (vcnt == 4) begin
        stall_ex = 1'b0;
        start = 1'b0;
      end
    end
    check("stallex_valid_cycles", 64'(vcnt), 64'd4);
    check("stallex_idle_stall", {63'd0, div_stall}, 64'd0);
    check("stallex_idle_held", result, exp);

    // Asynchronous reset in the middle of BUSY cycle 5.
    @(negedge clk);
    a = 32'hDEAD_BEEF; b = 32'd5; signed_div = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    check("pre_reset_stall", {63'd0, div_stall}, 64'd1);
    resetn = 1'b0;
    #1;
    check("midreset_result", result, 64'd0);
    check("midreset_stall", {63'd0, div_stall}, 64'd0);
    check("midreset_valid", {63'd0, result_valid}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    #1;
    check("postreset_stall", {63'd0, div_stall}, 64'd0);
    check("postreset_result", result, 64'd0);
    directed("after_reset", 1'b0, 32'hDEAD_BEEF, 32'd5, ref_div(1'b0, 32'hDEAD_BEEF, 32'd5));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
